// File: rtl/word_serializer_pkg.sv
// Shared types and widths for the serializer / deserializer pair.
package serializer_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} ser_state_t;
endpackage

// File: rtl/word_serializer_if.sv
// Memory read port and serial output link of the word serializer.
interface word_serializer_if #(
  parameter int WIDTH  = serializer_pkg::WORD_W,
  parameter int ADDR_W = serializer_pkg::ADDR_W
);
  logic              memRead;
  logic [ADDR_W-1:0] memAddress;
  logic [WIDTH-1:0]  memData;
  logic              memValid;
  logic              serialOut;
  logic              serialValid;
  logic              serialReady;

  modport master (
    output memRead, memAddress, serialOut, serialValid,
    input  memData, memValid, serialReady
  );

  modport slave (
    input  memRead, memAddress, serialOut, serialValid,
    output memData, memValid, serialReady
  );
endinterface

// File: rtl/word_serializer_shift_out_reg.sv
// Parallel-load, MSB-first left-shift register with accepted-bit counter.
module shift_out_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg  <= '0;
      count <= '0;
    end else if (load) begin
      sreg  <= data;
      count <= '0;
    end else if (shift) begin
      sreg  <= {sreg[WIDTH-2:0], 1'b0};
      count <= count + CNT_W'(1);
    end
  end

  assign msb  = sreg[WIDTH-1];
  // count holds the number of bits already accepted, so WIDTH-1 marks the final one
  assign last = (count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/word_serializer.sv
// Fetches words from data memory and shifts them out MSB-first over a valid/ready link.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | one-cycle read strobe at the current address
//   WAIT  | waiting for memValid, then loads the shift register
//   SHIFT | presenting bits, advancing on serialReady
//   DONE  | sDone pulse, finished if this was lastAddress
module word_serializer #(
  parameter int WIDTH  = serializer_pkg::WORD_W,
  parameter int ADDR_W = serializer_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] lastAddress,
  output logic              sDone,
  output logic              busy,
  output logic              finished,
  word_serializer_if.master bus
);
  import serializer_pkg::*;

  ser_state_t state;
  logic       mem_read;
  logic       serial_valid;
  logic       load;
  logic       shift;
  logic       msb;
  logic       last;

  assign load  = (state == WAIT) && bus.memValid;
  assign shift = (state == SHIFT) && bus.serialReady;

  shift_out_reg #(.WIDTH(WIDTH)) u_shift (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (bus.memData),
    .msb   (msb),
    .last  (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mem_read     <= 1'b0;
      serial_valid <= 1'b0;
      sDone        <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
    end else begin
      mem_read <= 1'b0;
      sDone    <= 1'b0;
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            mem_read <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (bus.memValid) begin
            state        <= SHIFT;
            serial_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (shift && last) begin
            state        <= DONE;
            serial_valid <= 1'b0;
            sDone        <= 1'b1;
            // address is stable for the whole word, so the match can be registered early
            finished     <= (address == lastAddress);
          end
        end
        DONE: begin
          if (!finished && start) begin
            state    <= FETCH;
            mem_read <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The counter advances on the edge that enters FETCH, so the read address is taken live.
  assign bus.memAddress  = mem_read ? address : '0;
  assign bus.memRead     = mem_read;
  assign bus.serialValid = serial_valid;
  assign bus.serialOut   = serial_valid & msb;
endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: memory, address counter and receiver models around word_serializer.
module tb_word_serializer;
  import serializer_pkg::*;

  typedef bit bitq_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] address;
  logic [15:0] lastAddress = 16'h0;
  logic        sDone, busy, finished;

  word_serializer_if bus ();

  word_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .address     (address),
    .lastAddress (lastAddress),
    .sDone       (sDone),
    .busy        (busy),
    .finished    (finished),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:65535];
  int          cycle = 0;
  bit          addr_load = 1'b0;
  logic [15:0] addr_init = 16'h0;
  int          lat_cfg = 1;
  int          ready_mode = 0;
  int          pat_idx = 0;
  bit          stray_arm = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [15:0] raddr = 16'h0;
  int          stable_err = 0;
  int          wait_err = 0;
  bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_out = 1'b0;
  bit          rx[$];
  logic [15:0] reads[$];
  int          sdone_q[$], fin_q[$], fetch_q[$];

  always @(posedge clock) cycle <= cycle + 1;

  // Address counter neighbour: advances once per sDone.
  always @(posedge clock) begin
    if (addr_load) address <= addr_init;
    else if (sDone) address <= address + 16'd1;
  end

  // Memory with configurable latency, plus link/handshake monitors.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend = 1'b0;
      bus.memValid <= 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (pend && bus.serialValid) wait_err++;
      bus.memValid <= 1'b0;
      if (bus.memRead) begin
        raddr = bus.memAddress;
        dly   = lat_cfg;
        pend  = 1'b1;
        reads.push_back(bus.memAddress);
        fetch_q.push_back(cycle);
      end
      if (pend) begin
        dly--;
        if (dly == 0) begin
          bus.memValid <= 1'b1;
          bus.memData  <= mem[raddr];
          pend = 1'b0;
        end
      end else if (stray_arm && rx.size() == 4) begin
        bus.memValid <= 1'b1;
        bus.memData  <= ~mem[raddr];
        stray_arm = 1'b0;
      end
      if (bus.serialValid && prev_valid && !prev_ready && bus.serialOut !== prev_out) stable_err++;
      prev_valid = bus.serialValid;
      prev_ready = bus.serialReady;
      prev_out   = bus.serialOut;
      if (bus.serialValid && bus.serialReady) rx.push_back(bus.serialOut);
      if (sDone) sdone_q.push_back(cycle);
      if (finished) fin_q.push_back(cycle);
    end
  end

  // Receiver ready: 0 = always, 1 = pattern 1,0,0,1, other = random.
  always @(negedge clock) begin
    case (ready_mode)
      0: bus.serialReady = 1'b1;
      1: begin
        bus.serialReady = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
      default: bus.serialReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference: the words from a0 onwards, each MSB first, concatenated.
  function automatic bitq_t ref_stream(input logic [15:0] a0, input int n);
    bitq_t q;
    logic [15:0] a;
    a = a0;
    for (int w = 0; w < n; w++) begin
      for (int b = WORD_W - 1; b >= 0; b--) q.push_back(mem[a][b]);
      a = a + 16'd1;
    end
    return q;
  endfunction

  function automatic int stream_errors(input bitq_t exp);
    int e = 0;
    if (rx.size() != exp.size()) e++;
    for (int i = 0; i < exp.size() && i < rx.size(); i++)
      if (rx[i] !== exp[i]) e++;
    return e;
  endfunction

  function automatic int addr_errors(input logic [15:0] a0, input int n);
    int e = 0;
    if (reads.size() != n) e++;
    for (int i = 0; i < n && i < reads.size(); i++)
      if (reads[i] !== a0 + 16'(i)) e++;
    return e;
  endfunction

  task automatic clear_logs();
    rx.delete(); reads.delete(); sdone_q.delete(); fin_q.delete(); fetch_q.delete();
    stable_err = 0;
    wait_err   = 0;
  endtask

  task automatic run_words(input logic [15:0] a0, input logic [15:0] last, input int lat,
                           input int mode, output bit timeout);
    logic [15:0] span;
    int n;
    span = last - a0;
    n = int'(span) + 1;
    lat_cfg = lat; ready_mode = mode; pat_idx = 0; lastAddress = last;
    clear_logs();
    addr_init = a0; addr_load = 1'b1;
    @(negedge clock);
    addr_load = 1'b0;
    start = 1'b1;
    timeout = 1'b1;
    for (int c = 0; c < n * 80 + 100; c++) begin
      @(negedge clock);
      if (reads.size() >= n) start = 1'b0;
      if (fin_q.size() != 0) begin
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    int bad = 0;
    addr_init = 16'h0; addr_load = 1'b1;
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if ({bus.memRead, bus.memAddress, bus.serialOut, bus.serialValid, sDone, busy, finished} !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_values: %0d cycles with a nonzero output, need 0", bad);
    end
    addr_load = 1'b0;
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (busy !== 1'b0 || bus.memRead !== 1'b0 || bus.serialValid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_after_reset: %0d active cycles with start low, need 0", bad);
    end
  endtask

  task automatic test_single_word();
    bit to;
    int e;
    mem[5] = 16'hA5C3;
    run_words(16'd5, 16'd5, 1, 0, to);
    tests++;
    if (to || addr_errors(16'd5, 1) != 0) begin
      fails++;
      $display("FAIL single_read: timeout=%0d reads=%0d first=%h, need 1 read at 0005",
               to, reads.size(), reads.size() > 0 ? reads[0] : 16'hxxxx);
    end
    e = stream_errors(ref_stream(16'd5, 1));
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL single_bits: %0d bits, %0d errors, need 16 bits 1010010111000011", rx.size(), e);
    end
    tests++;
    if (sdone_q.size() != 1 || fetch_q.size() != 1 || sdone_q[0] - fetch_q[0] != 18) begin
      fails++;
      $display("FAIL single_latency: %0d sDone, delay %0d, need 1 sDone 18 cycles after FETCH",
               sdone_q.size(), (sdone_q.size() > 0 && fetch_q.size() > 0) ? sdone_q[0] - fetch_q[0] : -1);
    end
    tests++;
    if (fin_q.size() != 1 || sdone_q.size() != 1 || fin_q[0] != sdone_q[0] || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_finished: %0d finished pulses, busy=%b, need 1 coincident with sDone and busy=0",
               fin_q.size(), busy);
    end
  endtask

  task automatic test_three_words();
    bit to;
    int e;
    mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hFFFF;
    run_words(16'd0, 16'd2, 1, 0, to);
    tests++;
    if (to || addr_errors(16'd0, 3) != 0 || sdone_q.size() != 3) begin
      fails++;
      $display("FAIL three_reads: timeout=%0d reads=%0d sDone=%0d, need reads 0,1,2 and 3 sDone",
               to, reads.size(), sdone_q.size());
    end
    e = stream_errors(ref_stream(16'd0, 3));
    tests++;
    if (e != 0) begin
      fails++;
      $display("FAIL three_bits: %0d bits, %0d errors, need 48 bits", rx.size(), e);
    end
    tests++;
    if (sdone_q.size() != 3 || sdone_q[1] - sdone_q[0] != 19 || sdone_q[2] - sdone_q[1] != 19) begin
      fails++;
      $display("FAIL back_to_back: sDone spacing %0d/%0d, need 19/19",
               sdone_q.size() > 1 ? sdone_q[1] - sdone_q[0] : -1,
               sdone_q.size() > 2 ? sdone_q[2] - sdone_q[1] : -1);
    end
    tests++;
    if (fin_q.size() != 1 || sdone_q.size() != 3 || fin_q[0] != sdone_q[2] || address !== 16'd3) begin
      fails++;
      $display("FAIL three_finished: %0d finished, address=%h, need 1 with third sDone, address 0003",
               fin_q.size(), address);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int e;
    logic [15:0] a;
    a = 16'($urandom);
    mem[a] = 16'($urandom);
    run_words(a, a, 1, 1, to);
    e = stream_errors(ref_stream(a, 1));
    tests++;
    if (to || e != 0 || sdone_q.size() != 1) begin
      fails++;
      $display("FAIL backpressure_bits: timeout=%0d %0d bits %0d errors %0d sDone, need word %h once",
               to, rx.size(), e, sdone_q.size(), mem[a]);
    end
    tests++;
    if (stable_err != 0) begin
      fails++;
      $display("FAIL backpressure_stable: %0d serialOut changes while stalled, need 0", stable_err);
    end
  endtask

  task automatic test_slow_memory();
    bit to;
    int e;
    logic [15:0] a;
    a = 16'($urandom);
    mem[a] = 16'($urandom);
    stray_arm = 1'b1;
    run_words(a, a, 7, 0, to);
    tests++;
    if (to || wait_err != 0 || sdone_q.size() != 1 || fetch_q.size() != 1 || sdone_q[0] - fetch_q[0] != 24) begin
      fails++;
      $display("FAIL slow_wait: timeout=%0d valid-in-wait=%0d delay %0d, need 0 and 24",
               to, wait_err, (sdone_q.size() > 0 && fetch_q.size() > 0) ? sdone_q[0] - fetch_q[0] : -1);
    end
    e = stream_errors(ref_stream(a, 1));
    tests++;
    if (e != 0 || stray_arm != 1'b0) begin
      fails++;
      $display("FAIL stray_valid: %0d bit errors, stray pending=%0d, need 0 and 0", e, stray_arm);
    end
    stray_arm = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    bit to;
    int e;
    logic [15:0] a;
    a = 16'($urandom);
    mem[a] = 16'($urandom);
    lat_cfg = 1; ready_mode = 0; lastAddress = a;
    clear_logs();
    addr_init = a; addr_load = 1'b1;
    @(negedge clock);
    addr_load = 1'b0;
    start = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (rx.size() >= 9) begin
        to = 1'b0;
        break;
      end
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (to || {bus.memRead, bus.serialOut, bus.serialValid, sDone, busy, finished} !== '0) begin
      fails++;
      $display("FAIL reset_async: timeout=%0d valid=%b busy=%b, need all outputs 0 at once",
               to, bus.serialValid, busy);
    end
    repeat (2) @(negedge clock);
    tests++;
    if (sdone_q.size() != 0 || address !== a) begin
      fails++;
      $display("FAIL reset_no_sdone: %0d sDone, address=%h, need 0 and %h", sdone_q.size(), address, a);
    end
    clear_logs();
    reset = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (reads.size() >= 1) start = 1'b0;
      if (fin_q.size() != 0) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clock);
    e = stream_errors(ref_stream(a, 1));
    tests++;
    if (to || addr_errors(a, 1) != 0 || e != 0 || sdone_q.size() != 1) begin
      fails++;
      $display("FAIL reset_restart: timeout=%0d reads=%0d bit errors=%0d sDone=%0d, need fresh read at %h",
               to, reads.size(), e, sdone_q.size(), a);
    end
  endtask

  task automatic test_wrap();
    bit to;
    int e;
    for (int i = 0; i < 4; i++) mem[16'hFFFE + 16'(i)] = 16'($urandom);
    run_words(16'hFFFE, 16'h0001, $urandom_range(1, 3), 2, to);
    e = stream_errors(ref_stream(16'hFFFE, 4));
    tests++;
    if (to || addr_errors(16'hFFFE, 4) != 0 || e != 0 || sdone_q.size() != 4 || fin_q.size() != 1) begin
      fails++;
      $display("FAIL wrap: timeout=%0d reads=%0d bit errors=%0d sDone=%0d finished=%0d, need 4/0/4/1",
               to, reads.size(), e, sdone_q.size(), fin_q.size());
    end
  endtask

  task automatic test_random();
    bit to;
    int e, n, lat;
    logic [15:0] a, l;
    for (int it = 0; it < 4; it++) begin
      a   = 16'($urandom);
      n   = $urandom_range(1, 3);
      l   = a + 16'(n - 1);
      lat = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) mem[a + 16'(i)] = 16'($urandom);
      run_words(a, l, lat, 2, to);
      e = stream_errors(ref_stream(a, n));
      tests++;
      if (to || addr_errors(a, n) != 0 || e != 0 || sdone_q.size() != n || fin_q.size() != 1 || stable_err != 0) begin
        fails++;
        $display("FAIL random_%0d: start %h words %0d lat %0d: timeout=%0d bit errors=%0d sDone=%0d finished=%0d stalls=%0d",
                 it, a, n, lat, to, e, sdone_q.size(), fin_q.size(), stable_err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_three_words();
    test_backpressure();
    test_slow_memory();
    test_reset_mid_word();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
